bioee_vector_sequencer: RTL and testbench

Playback controller for the vector FIFO read side, in the vectorclk domain. It paces vector reads at a programmable rate, waits for a prefill level before starting, and counts vectors against a programmed length. It detects underflow and drives the registered 16-bit vector output bus, presenting a programmable idle vector whenever playback is not running.

---
 rtl/bioee_vector_pkg.sv | 12 +
 rtl/bioee_vector_tickgen.sv | 30 +++
 rtl/bioee_vector_sequencer.sv | 141 ++++++++++++++
 tb/tb_bioee_vector_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bioee_vector_pkg.sv
// Shared state encoding and default widths for the vector playback sequencer.
package bioee_vector_pkg;
    localparam int CNT_W_DEFAULT = 24;
    localparam int DIV_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        RUN,
        DRAIN
    } seq_state_t;
endpackage

// File: rtl/bioee_vector_tickgen.sv
// Down-counting prescaler: ticks when enabled at zero, then reloads so ticks repeat every reload_value+1 cycles.
module bioee_vector_tickgen
    import bioee_vector_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] reload_value,
    output logic             tick
);
    logic [DIV_W-1:0] count;

    assign tick = enable && (count == '0);

    // A tick has priority over load so the very first enabled cycle can tick and reload at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= reload_value;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count - DIV_W'(1);
        end
    end
endmodule

// File: rtl/bioee_vector_sequencer.sv
// Vector FIFO playback controller: paced reads, optional prefill wait, length counting and underflow detection.
module bioee_vector_sequencer
    import bioee_vector_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             vectorclk,
    input  logic             vectorreset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] cfg_divider,
    input  logic [CNT_W-1:0] cfg_length,
    input  logic             cfg_prefill_en,
    input  logic             cfg_abort_on_underflow,
    input  logic [15:0]      cfg_idle_vector,
    input  logic [15:0]      fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_prog_full,
    output logic             fifo_rd_en,
    output logic [15:0]      vectoroutput,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [CNT_W-1:0] vector_count
);
    seq_state_t       state;
    logic [DIV_W-1:0] sh_divider;
    logic [CNT_W-1:0] sh_length;
    logic             sh_abort;
    logic [15:0]      sh_idle_vector;
    logic [CNT_W-1:0] issued;
    logic             rd_valid;
    logic             aborted;

    logic             start_go;
    logic             run_en;
    logic             tick;
    logic             tick_load;
    logic [DIV_W-1:0] eff_divider;
    logic [CNT_W-1:0] eff_length;
    logic             eff_abort;
    logic [CNT_W-1:0] issued_next;

    // On the start edge the shadows are not loaded yet, so that edge's read decision uses live cfg.
    always_comb begin
        start_go    = start && !stop && (state == IDLE);
        eff_divider = (state == IDLE) ? cfg_divider : sh_divider;
        eff_length  = (state == IDLE) ? cfg_length : sh_length;
        eff_abort   = (state == IDLE) ? cfg_abort_on_underflow : sh_abort;
        issued_next = ((state == IDLE) ? '0 : issued) + CNT_W'(1);
        run_en      = (start_go && !cfg_prefill_en)
                   || ((state == PREFILL) && fifo_prog_full && !stop)
                   || ((state == RUN) && !stop);
        tick_load   = (state != RUN) || stop;
    end

    bioee_vector_tickgen #(.DIV_W(DIV_W)) u_tickgen (
        .clk          (vectorclk),
        .rst_n        (vectorreset_n),
        .load         (tick_load),
        .enable       (run_en),
        .reload_value (eff_divider),
        .tick         (tick)
    );

    always_ff @(posedge vectorclk or negedge vectorreset_n) begin
        if (!vectorreset_n) begin
            state          <= IDLE;
            sh_divider     <= '0;
            sh_length      <= '0;
            sh_abort       <= 1'b0;
            sh_idle_vector <= '0;
            issued         <= '0;
            rd_valid       <= 1'b0;
            aborted        <= 1'b0;
            fifo_rd_en     <= 1'b0;
            vectoroutput   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            underflow      <= 1'b0;
            vector_count   <= '0;
        end else begin
            done       <= 1'b0;
            fifo_rd_en <= 1'b0;
            rd_valid   <= fifo_rd_en;

            if (state == IDLE) begin
                vectoroutput <= cfg_idle_vector;
                if (start_go) begin
                    sh_divider     <= cfg_divider;
                    sh_length      <= cfg_length;
                    sh_abort       <= cfg_abort_on_underflow;
                    sh_idle_vector <= cfg_idle_vector;
                    issued         <= '0;
                    aborted        <= 1'b0;
                    vector_count   <= '0;
                    underflow      <= 1'b0;
                    busy           <= 1'b1;
                    state          <= cfg_prefill_en ? PREFILL : RUN;
                end
            end else if (stop) begin
                // Data arriving for an in-flight read is simply never latched.
                state        <= IDLE;
                busy         <= 1'b0;
                vectoroutput <= sh_idle_vector;
            end else begin
                if (rd_valid) begin
                    vectoroutput <= fifo_dout;
                    vector_count <= (vector_count == '1) ? vector_count
                                                         : vector_count + CNT_W'(1);
                end
                if ((state == PREFILL) && fifo_prog_full) begin
                    state <= RUN;
                end
                if ((state == DRAIN) && !fifo_rd_en && !rd_valid) begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    done         <= !aborted;
                    vectoroutput <= sh_idle_vector;
                end
            end

            if (tick) begin
                if (!fifo_empty) begin
                    fifo_rd_en <= 1'b1;
                    issued     <= issued_next;
                    if ((eff_length != '0) && (issued_next == eff_length)) begin
                        state <= DRAIN;
                    end
                end else begin
                    underflow <= 1'b1;
                    if (eff_abort) begin
                        state   <= DRAIN;
                        aborted <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bioee_vector_sequencer.sv
// Self-checking bench: a queue-based FIFO model feeds the sequencer, and an event-level
// reference model predicts read slots, latched vectors, completion and underflow per cycle.
module tb_bioee_vector_sequencer;
    localparam int CNT_W = 24;
    localparam int DIV_W = 16;

    logic             vectorclk = 1'b0;
    logic             vectorreset_n;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] cfg_divider;
    logic [CNT_W-1:0] cfg_length;
    logic             cfg_prefill_en;
    logic             cfg_abort_on_underflow;
    logic [15:0]      cfg_idle_vector;
    logic [15:0]      fifo_dout;
    logic             fifo_empty;
    logic             fifo_prog_full;
    logic             fifo_rd_en;
    logic [15:0]      vectoroutput;
    logic             busy;
    logic             done;
    logic             underflow;
    logic [CNT_W-1:0] vector_count;

    always #5 vectorclk = ~vectorclk;

    bioee_vector_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .vectorclk              (vectorclk),
        .vectorreset_n          (vectorreset_n),
        .start                  (start),
        .stop                   (stop),
        .cfg_divider            (cfg_divider),
        .cfg_length             (cfg_length),
        .cfg_prefill_en         (cfg_prefill_en),
        .cfg_abort_on_underflow (cfg_abort_on_underflow),
        .cfg_idle_vector        (cfg_idle_vector),
        .fifo_dout              (fifo_dout),
        .fifo_empty             (fifo_empty),
        .fifo_prog_full         (fifo_prog_full),
        .fifo_rd_en             (fifo_rd_en),
        .vectoroutput           (vectoroutput),
        .busy                   (busy),
        .done                   (done),
        .underflow              (underflow),
        .vector_count           (vector_count)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int curN = 0;

    logic [15:0] fq[$];
    logic [15:0] words[$];

    // Scenario description
    int scDiv, scLen, scPrefill, scWait, scAbort, scStop, scInit, scRefill, scRefillAt;

    // Reference model results, in cycles counted from the start edge
    int rn[$];
    int uAt, endAt, doneAt;
    logic [15:0] shIdle, liveIdle;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s n=%0d got=%0h expected=%0h", tag, curN, got, exp);
        end
    endtask

    task automatic setScenario(input int d, input int len, input int pre, input int w,
                               input int ab, input int st, input int init,
                               input int refill, input int refillAt);
        scDiv = d; scLen = len; scPrefill = pre; scWait = w; scAbort = ab;
        scStop = st; scInit = init; scRefill = refill; scRefillAt = refillAt;
    endtask

    // Ticks fall every divider+1 cycles from the first RUN decision; a tick reads when pushed
    // words outnumber reads so far, otherwise it is an underflow. Playback ends at the length,
    // an aborting underflow, or stop; it leaves once the last read has been latched.
    task automatic computeModel();
        int n, reads, pushed, nEnd, p;
        bit ab, stopped;
        rn.delete();
        uAt = -1; nEnd = -1; ab = 0; stopped = 0; reads = 0;
        p = scPrefill ? scWait + 1 : 0;
        for (int j = 0; j < 2000; j++) begin
            n = p + j * (scDiv + 1);
            if (scStop >= 0 && n >= scStop) break;
            pushed = scInit + ((scRefill > 0 && scRefillAt < n) ? scRefill : 0);
            if (pushed > reads) begin
                rn.push_back(n);
                reads++;
                if (scLen != 0 && reads == scLen) begin
                    nEnd = n;
                    break;
                end
            end else begin
                if (uAt < 0) uAt = n;
                if (scAbort != 0) begin
                    nEnd = n;
                    ab = 1;
                    break;
                end
            end
        end
        endAt = -1;
        if (nEnd >= 0) begin
            endAt = nEnd + 1;
            if (reads > 0 && rn[reads-1] + 3 > endAt) endAt = rn[reads-1] + 3;
        end
        if (scStop >= 0 && (endAt < 0 || scStop < endAt)) begin
            endAt = scStop;
            stopped = 1;
        end
        doneAt = (!stopped && !ab) ? endAt : -1;
    endtask

    task automatic applyStimulus();
        bit popNow, expRd;
        int cnt;
        logic [15:0] expOut;
        words.delete();
        for (int i = 0; i < scInit + scRefill; i++) words.push_back(16'($urandom));
        fq.delete();
        for (int i = 0; i < scInit; i++) fq.push_back(words[i]);
        computeModel();

        @(negedge vectorclk);
        cfg_divider            = DIV_W'(scDiv);
        cfg_length             = CNT_W'(scLen);
        cfg_prefill_en         = (scPrefill != 0);
        cfg_abort_on_underflow = (scAbort != 0);
        cfg_idle_vector        = 16'($urandom);
        shIdle                 = cfg_idle_vector;
        liveIdle               = cfg_idle_vector;
        fifo_prog_full         = (scPrefill != 0) ? 1'b0 : 1'($urandom);
        fifo_empty             = (fq.size() == 0);
        start = 1'b1;
        stop  = 1'b0;
        @(posedge vectorclk);
        #1;

        for (int n = 0; n <= endAt + 2; n++) begin
            @(negedge vectorclk);
            curN = n;
            expRd = 0;
            foreach (rn[i]) if (rn[i] == n) expRd = 1;
            cnt = 0;
            foreach (rn[i]) if (rn[i] + 2 <= n && rn[i] + 2 < endAt) cnt++;
            if (n > endAt)       expOut = liveIdle;
            else if (n == endAt) expOut = shIdle;
            else if (cnt > 0)    expOut = words[cnt-1];
            else                 expOut = shIdle;
            checkOutput("rd_en", 32'(fifo_rd_en), 32'(expRd));
            checkOutput("vectoroutput", 32'(vectoroutput), 32'(expOut));
            checkOutput("busy", 32'(busy), 32'(n < endAt));
            checkOutput("done", 32'(done), 32'(n == doneAt));
            checkOutput("underflow", 32'(underflow), 32'(uAt >= 0 && n >= uAt));
            checkOutput("vector_count", 32'(vector_count), 32'(cnt));

            // Inputs for the next edge; cfg is scrambled to show only the shadows matter
            start = (n == 1 && n + 1 < endAt);
            stop  = (n + 1 == scStop);
            if (n == 0) begin
                cfg_divider            = DIV_W'($urandom);
                cfg_length             = CNT_W'($urandom);
                cfg_prefill_en         = 1'($urandom);
                cfg_abort_on_underflow = 1'($urandom);
                cfg_idle_vector        = 16'($urandom);
                liveIdle               = cfg_idle_vector;
            end
            if (scPrefill != 0) fifo_prog_full = (n >= scWait);
            if (scRefill > 0 && n == scRefillAt) begin
                for (int i = scInit; i < scInit + scRefill; i++) fq.push_back(words[i]);
                fifo_empty = 1'b0;
            end
            popNow = fifo_rd_en;
            @(posedge vectorclk);
            #1;
            if (popNow && fq.size() > 0) fifo_dout = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic randomScenario();
        scDiv = int'($urandom_range(0, 4));
        scLen = int'($urandom_range(1, 8));
        if ($urandom_range(0, 3) == 0) scLen = 0;
        scPrefill = int'($urandom_range(0, 1));
        scWait = int'($urandom_range(0, 5));
        scAbort = int'($urandom_range(0, 1));
        scStop = -1;
        if (scDiv == 0) begin
            scInit = (scLen == 0) ? 40 : scLen;
            scRefill = 0;
            scRefillAt = 0;
        end else begin
            scInit = int'($urandom_range(0, (scLen == 0) ? 6 : scLen));
            scRefill = int'($urandom_range(0, 4));
            scRefillAt = int'($urandom_range(0, 20));
        end
        if ($urandom_range(0, 2) == 0) scStop = int'($urandom_range(1, 30));
        if ((scLen == 0 || scInit + scRefill < scLen) && scAbort == 0 && scStop < 0)
            scStop = int'($urandom_range(1, 40));
        if (scDiv == 0 && scLen == 0) scStop = int'($urandom_range(1, 30));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        start = 0; stop = 0;
        cfg_divider = '0; cfg_length = '0; cfg_prefill_en = 0;
        cfg_abort_on_underflow = 0; cfg_idle_vector = 16'h1234;
        fifo_dout = '0; fifo_empty = 1; fifo_prog_full = 0;
        vectorreset_n = 1;
        #2 vectorreset_n = 0;
        #10;
        curN = -1;
        checkOutput("reset_vectoroutput", 32'(vectoroutput), 32'h0);
        checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_underflow", 32'(underflow), 32'h0);
        checkOutput("reset_count", 32'(vector_count), 32'h0);
        @(negedge vectorclk);
        vectorreset_n = 1;
        cfg_idle_vector = 16'hA5C3;
        @(negedge vectorclk);
        checkOutput("idle_after_reset", 32'(vectoroutput), 32'hA5C3);

        $display("[TB] back-to-back length 4");
        setScenario(0, 4, 0, 0, 0, -1, 4, 0, 0);
        applyStimulus();
        $display("[TB] divider 3 length 3");
        setScenario(3, 3, 0, 0, 0, -1, 3, 0, 0);
        applyStimulus();
        $display("[TB] prefill wait 50");
        setScenario(1, 2, 1, 50, 0, -1, 2, 0, 0);
        applyStimulus();
        $display("[TB] underflow without abort, refill");
        setScenario(1, 5, 0, 0, 0, -1, 2, 3, 10);
        applyStimulus();
        $display("[TB] underflow with abort");
        setScenario(2, 5, 0, 0, 1, -1, 2, 0, 0);
        applyStimulus();
        $display("[TB] stop with read in flight");
        setScenario(0, 0, 0, 0, 0, 6, 20, 0, 0);
        applyStimulus();

        $display("[TB] start and stop together in idle");
        fq.delete();
        fifo_empty = 0;
        @(negedge vectorclk);
        start = 1; stop = 1;
        @(negedge vectorclk);
        start = 0; stop = 0;
        curN = 0;
        checkOutput("startstop_busy", 32'(busy), 32'h0);
        @(negedge vectorclk);
        curN = 1;
        checkOutput("startstop_rd_en", 32'(fifo_rd_en), 32'h0);
        checkOutput("startstop_busy2", 32'(busy), 32'h0);

        $display("[TB] reset during playback");
        cfg_divider = '0; cfg_length = '0; cfg_prefill_en = 0; cfg_abort_on_underflow = 0;
        fifo_dout = 16'h5A5A; fifo_empty = 0;
        @(negedge vectorclk);
        start = 1;
        @(negedge vectorclk);
        start = 0;
        repeat (4) @(negedge vectorclk);
        fifo_empty = 1;
        repeat (3) @(negedge vectorclk);
        curN = 0;
        checkOutput("midrun_busy_before", 32'(busy), 32'h1);
        checkOutput("midrun_underflow_before", 32'(underflow), 32'h1);
        #2 vectorreset_n = 0;
        #1;
        checkOutput("midrun_vectoroutput", 32'(vectoroutput), 32'h0);
        checkOutput("midrun_rd_en", 32'(fifo_rd_en), 32'h0);
        checkOutput("midrun_busy", 32'(busy), 32'h0);
        checkOutput("midrun_underflow", 32'(underflow), 32'h0);
        checkOutput("midrun_count", 32'(vector_count), 32'h0);
        @(negedge vectorclk);
        vectorreset_n = 1;
        fifo_empty = 1;

        for (int s = 0; s < 12; s++) begin
            randomScenario();
            $display("[TB] random run %0d: div=%0d len=%0d prefill=%0d wait=%0d abort=%0d stop=%0d init=%0d refill=%0d@%0d",
                     s, scDiv, scLen, scPrefill, scWait, scAbort, scStop, scInit, scRefill, scRefillAt);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
